// File: rtl/bubsys_sram_loader.sv
`default_nettype none
// ============================================================================
// Module   : bubsys_sram_loader
// Purpose  : Writes a block of SRAM words, either from a valid/ready stream
//            (LOAD) or as a repeated constant (FILL), and keeps a running
//            modulo-2^DW sum of every word written.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_MCLK        system clock, rising edge
//   i_RST         synchronous active-high reset
//   i_START_LOAD  start a stream load (wins over i_START_FILL)
//   i_START_FILL  start a constant fill
//   i_BASE        first SRAM address of the operation
//   i_LEN         number of words, 0..2^AW
//   i_FILLVAL     constant used by FILL
//   i_DIN         stream data word
//   i_DIN_VALID   stream word valid
//   o_DIN_READY   stream word accepted this cycle when valid
//   o_RAM_ADDR    SRAM write address
//   o_RAM_DIN     SRAM write data
//   o_RAM_WR      SRAM write strobe, one word per high cycle
//   o_BUSY        operation in progress
//   o_DONE        one-cycle completion pulse
//   o_SUM         modulo-2^DW sum of words written by current/last operation
// ============================================================================
module bubsys_sram_loader #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          i_MCLK,
  input  logic          i_RST,
  input  logic          i_START_LOAD,
  input  logic          i_START_FILL,
  input  logic [AW-1:0] i_BASE,
  input  logic [AW:0]   i_LEN,
  input  logic [DW-1:0] i_FILLVAL,
  input  logic [DW-1:0] i_DIN,
  input  logic          i_DIN_VALID,
  output logic          o_DIN_READY,
  output logic [AW-1:0] o_RAM_ADDR,
  output logic [DW-1:0] o_RAM_DIN,
  output logic          o_RAM_WR,
  output logic          o_BUSY,
  output logic          o_DONE,
  output logic [DW-1:0] o_SUM
);

  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [DW-1:0] fillval;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_wr;
  logic [DW-1:0] sum;

  logic          cnt_zero;
  logic          cnt_last;
  logic          accept;

  assign cnt_zero = (cnt == '0);
  assign cnt_last = (cnt == CW'(1));
  // Ready comes only from registered state, never from i_DIN_VALID.
  assign accept   = (state == LOAD) && !cnt_zero && i_DIN_VALID;

  // State register
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode. The edge that issues the final write also enters
  // DONE, so the last strobe lines up with the o_DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_START_LOAD) begin
          state_nxt = LOAD;
        end else if (i_START_FILL) begin
          state_nxt = FILL;
        end
      end
      LOAD: begin
        if (cnt_zero || (accept && cnt_last)) begin
          state_nxt = DONE;
        end
      end
      FILL: begin
        if (cnt_zero || cnt_last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: pointer, counter, write port registers and running sum.
  // The write strobe defaults low every edge; address/data/sum hold.
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      ptr      <= '0;
      cnt      <= '0;
      fillval  <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_wr   <= 1'b0;
      sum      <= '0;
    end else begin
      ram_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (i_START_LOAD || i_START_FILL) begin
            ptr <= i_BASE;
            cnt <= i_LEN;
            sum <= '0;
            if (!i_START_LOAD) begin
              fillval <= i_FILLVAL;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            ram_addr <= ptr;
            ram_din  <= i_DIN;
            ram_wr   <= 1'b1;
            ptr      <= ptr + AW'(1);
            cnt      <= cnt - CW'(1);
            sum      <= sum + i_DIN;
          end
        end
        FILL: begin
          if (!cnt_zero) begin
            ram_addr <= ptr;
            ram_din  <= fillval;
            ram_wr   <= 1'b1;
            ptr      <= ptr + AW'(1);
            cnt      <= cnt - CW'(1);
            sum      <= sum + fillval;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_DIN_READY = (state == LOAD) && !cnt_zero;
  assign o_RAM_ADDR  = ram_addr;
  assign o_RAM_DIN   = ram_din;
  assign o_RAM_WR    = ram_wr;
  assign o_BUSY      = (state != IDLE);
  assign o_DONE      = (state == DONE);
  assign o_SUM       = sum;

endmodule
`default_nettype wire

// File: tb/tb_bubsys_sram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bubsys_sram_loader
// Purpose  : Directed self-checking bench for bubsys_sram_loader (AW=10,
//            DW=8). Inputs change and outputs are checked 1 ns after each
//            rising edge; a negedge monitor logs every SRAM write and every
//            o_DONE cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bubsys_sram_loader;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_load;
  logic          start_fill;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic [DW-1:0] fillval;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_wr;
  logic          busy;
  logic          done;
  logic [DW-1:0] sum;

  int n_assert = 0;
  int n_fail   = 0;

  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            done_cnt = 0;

  bubsys_sram_loader #(.AW(AW), .DW(DW)) dut (
    .i_MCLK      (clk),
    .i_RST       (rst),
    .i_START_LOAD(start_load),
    .i_START_FILL(start_fill),
    .i_BASE      (base),
    .i_LEN       (len),
    .i_FILLVAL   (fillval),
    .i_DIN       (din),
    .i_DIN_VALID (din_valid),
    .o_DIN_READY (din_ready),
    .o_RAM_ADDR  (ram_addr),
    .o_RAM_DIN   (ram_din),
    .o_RAM_WR    (ram_wr),
    .o_BUSY      (busy),
    .o_DONE      (done),
    .o_SUM       (sum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_wr === 1'b1) begin
      wa_q.push_back(ram_addr);
      wd_q.push_back(ram_din);
    end
    if (done === 1'b1) begin
      done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=no finish expected=finish");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".busy"},  32'(busy),      32'h0);
    chk({tag, ".done"},  32'(done),      32'h0);
    chk({tag, ".ready"}, 32'(din_ready), 32'h0);
    chk({tag, ".wr"},    32'(ram_wr),    32'h0);
    chk({tag, ".addr"},  32'(ram_addr),  32'h0);
    chk({tag, ".din"},   32'(ram_din),   32'h0);
    chk({tag, ".sum"},   32'(sum),       32'h0);
  endtask

  initial begin
    int            s0;
    int            d0;
    logic [DW-1:0] words [4];
    logic [AW-1:0] a;
    bit            seen [1024];
    int            bad;

    rst = 1'b1; start_load = 1'b0; start_fill = 1'b0;
    base = '0; len = '0; fillval = '0; din = '0; din_valid = 1'b0;
    step(2);
    chk_reset_outputs("reset");
    rst = 1'b0;
    step(1);

    // ---- LOAD 0x010, len 4, stream with valid gaps ----
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    s0 = wa_q.size(); d0 = done_cnt;
    base = 10'h010; len = 11'd4; start_load = 1'b1;
    step(1);
    start_load = 1'b0;
    chk("load.busy", 32'(busy), 32'h1);
    chk("load.ready", 32'(din_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      din_valid = 1'b0;
      step(i + 1);
      if (i > 0) chk("load.gap_wr", 32'(ram_wr), 32'h0);
      din = words[i]; din_valid = 1'b1;
      step(1);
      din_valid = 1'b0;
      chk("load.wr", 32'(ram_wr), 32'h1);
      chk("load.addr", 32'(ram_addr), 32'h010 + 32'(i));
      chk("load.din", 32'(ram_din), 32'(words[i]));
      chk("load.done", 32'(done), (i == 3) ? 32'h1 : 32'h0);
    end
    chk("load.sum", 32'(sum), 32'hAA);
    chk("load.ready_done", 32'(din_ready), 32'h0);
    step(1);
    chk("load.idle_busy", 32'(busy), 32'h0);
    chk("load.idle_done", 32'(done), 32'h0);
    chk("load.idle_wr", 32'(ram_wr), 32'h0);
    step(1);
    chk("load.hold_sum", 32'(sum), 32'hAA);
    chk("load.hold_addr", 32'(ram_addr), 32'h013);
    chk("load.hold_din", 32'(ram_din), 32'h44);
    chk("load.nwrites", 32'(wa_q.size() - s0), 32'd4);
    chk("load.ndone", 32'(done_cnt - d0), 32'd1);

    // ---- FILL 0x3FE, len 4, 0x5A, wraps past top of memory ----
    s0 = wa_q.size(); d0 = done_cnt;
    base = 10'h3FE; len = 11'd4; fillval = 8'h5A; start_fill = 1'b1;
    step(1);
    start_fill = 1'b0;
    chk("fill.busy", 32'(busy), 32'h1);
    chk("fill.ready", 32'(din_ready), 32'h0);
    chk("fill.sum_clear", 32'(sum), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      a = 10'h3FE + 10'(i);
      chk("fill.wr", 32'(ram_wr), 32'h1);
      chk("fill.addr", 32'(ram_addr), 32'(a));
      chk("fill.din", 32'(ram_din), 32'h5A);
      chk("fill.done", 32'(done), (i == 3) ? 32'h1 : 32'h0);
    end
    chk("fill.sum", 32'(sum), 32'h68);
    step(1);
    chk("fill.idle_wr", 32'(ram_wr), 32'h0);
    chk("fill.idle_busy", 32'(busy), 32'h0);
    chk("fill.nwrites", 32'(wa_q.size() - s0), 32'd4);
    chk("fill.ndone", 32'(done_cnt - d0), 32'd1);

    // ---- Simultaneous starts, len 2: LOAD wins; starts while busy ignored;
    //      valid held high after the last beat ----
    s0 = wa_q.size(); d0 = done_cnt;
    base = 10'h100; len = 11'd2; fillval = 8'h77;
    start_load = 1'b1; start_fill = 1'b1;
    step(1);
    start_load = 1'b0; start_fill = 1'b0;
    chk("both.ready", 32'(din_ready), 32'h1);
    step(2);
    chk("both.no_fill_wr", 32'(ram_wr), 32'h0);
    chk("both.still_ready", 32'(din_ready), 32'h1);
    din = 8'h01; din_valid = 1'b1;
    start_load = 1'b1; start_fill = 1'b1; base = 10'h3AA; len = 11'd9;
    step(1);
    start_load = 1'b0; start_fill = 1'b0;
    chk("both.wr0_addr", 32'(ram_addr), 32'h100);
    chk("both.wr0_din", 32'(ram_din), 32'h01);
    din = 8'h02;
    step(1);
    chk("both.wr1_addr", 32'(ram_addr), 32'h101);
    chk("both.wr1_done", 32'(done), 32'h1);
    din = 8'h03;
    step(1);
    chk("both.after_wr", 32'(ram_wr), 32'h0);
    chk("both.after_busy", 32'(busy), 32'h0);
    step(2);
    din_valid = 1'b0;
    chk("both.idle_ready", 32'(din_ready), 32'h0);
    chk("both.sum", 32'(sum), 32'h03);
    chk("both.nwrites", 32'(wa_q.size() - s0), 32'd2);
    chk("both.ndone", 32'(done_cnt - d0), 32'd1);

    // ---- len 0, LOAD then FILL ----
    s0 = wa_q.size(); d0 = done_cnt;
    base = 10'h055; len = 11'd0; start_load = 1'b1;
    step(1);
    start_load = 1'b0;
    chk("len0l.ready", 32'(din_ready), 32'h0);
    chk("len0l.done_early", 32'(done), 32'h0);
    step(1);
    chk("len0l.done", 32'(done), 32'h1);
    chk("len0l.wr", 32'(ram_wr), 32'h0);
    chk("len0l.sum", 32'(sum), 32'h0);
    step(1);
    fillval = 8'hC3; start_fill = 1'b1;
    step(1);
    start_fill = 1'b0;
    chk("len0f.busy", 32'(busy), 32'h1);
    step(1);
    chk("len0f.done", 32'(done), 32'h1);
    chk("len0f.wr", 32'(ram_wr), 32'h0);
    step(1);
    chk("len0.nwrites", 32'(wa_q.size() - s0), 32'd0);
    chk("len0.ndone", 32'(done_cnt - d0), 32'd2);

    // ---- Full-memory FILL, len 2^AW, starting mid-array ----
    s0 = wa_q.size();
    base = 10'h155; len = 11'h400; fillval = 8'h03; start_fill = 1'b1;
    step(1);
    start_fill = 1'b0;
    step(1024);
    chk("full.done", 32'(done), 32'h1);
    chk("full.last_addr", 32'(ram_addr), 32'h154);
    chk("full.sum", 32'(sum), 32'h00);
    step(1);
    chk("full.nwrites", 32'(wa_q.size() - s0), 32'd1024);
    bad = 0;
    foreach (seen[k]) seen[k] = 1'b0;
    for (int k = s0; k < wa_q.size(); k++) begin
      if (seen[wa_q[k]]) bad++;
      seen[wa_q[k]] = 1'b1;
    end
    foreach (seen[k]) if (!seen[k]) bad++;
    chk("full.each_once", 32'(bad), 32'd0);

    // ---- Reset after 2 of 8 FILL writes ----
    s0 = wa_q.size(); d0 = done_cnt;
    base = 10'h020; len = 11'd8; fillval = 8'h10; start_fill = 1'b1;
    step(1);
    start_fill = 1'b0;
    step(2);
    chk("abort.wr2_addr", 32'(ram_addr), 32'h021);
    rst = 1'b1;
    step(1);
    chk_reset_outputs("abort");
    rst = 1'b0;
    step(10);
    chk("abort.nwrites", 32'(wa_q.size() - s0), 32'd2);
    chk("abort.ndone", 32'(done_cnt - d0), 32'd0);
    chk("abort.idle_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
